// File: rtl/oqpsk_pkg.sv
// rtl/oqpsk_pkg.sv - shared OQPSK constants, polarity map and FSM state encoding
// Purpose: common definitions for the OQPSK modulator and bit-recovery receiver.
// Ports: none (package).
package oqpsk_pkg;

  localparam int DEF_SAMPLE_W   = 12;
  localparam int DEF_SPB        = 16;
  localparam int DEF_MAG_THRESH = 64;

  // Bit value that maps to a positive rail level.
  localparam logic POS_BIT = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_TRACK = 2'd2
  } state_t;

  // Rail polarity for a bit: +1 for POS_BIT, -1 otherwise.
  function automatic int bit_level(input logic b);
    return (b == POS_BIT) ? 1 : -1;
  endfunction

endpackage

// File: rtl/oqpsk_integrate_dump.sv
// rtl/oqpsk_integrate_dump.sv - signed integrate-and-dump accumulator for one rail
// Purpose: accumulates sign-extended samples; sum includes the current sample.
// Ports:
//   clk    in  1         clock
//   rstn   in  1         synchronous reset, active-low
//   clear  in  1         force accumulator to 0
//   add    in  1         accept the current sample
//   start  in  1         treat the stored total as 0 for this sample (new window)
//   dump   in  1         this sample closes the window; restart from 0 afterwards
//   sample in  SAMPLE_W  signed sample
//   sum    out AW        running total including the current sample
module oqpsk_integrate_dump #(
  parameter int SAMPLE_W = 12,
  parameter int AW       = 17
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                clear,
  input  logic                add,
  input  logic                start,
  input  logic                dump,
  input  logic [SAMPLE_W-1:0] sample,
  output logic [AW-1:0]       sum
);

  logic [AW-1:0] acc;
  logic [AW-1:0] ext;

  always_comb begin
    ext = {{(AW-SAMPLE_W){sample[SAMPLE_W-1]}}, sample};
    sum = (start ? '0 : acc) + ext;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (add) begin
      acc <= dump ? '0 : sum;
    end
  end

endmodule

// File: rtl/oqpsk_bit_recovery.sv
// rtl/oqpsk_bit_recovery.sv - OQPSK half-symbol-offset integrate-and-dump bit recovery
// Purpose: integrates I over phases 0..2*SPB-1 and Q over SPB..SPB-1 (wrapping),
//   slices each dump to a hard bit and emits bits in I,Q,I,Q order.
// Ports:
//   CLK      in  1         clock
//   RST      in  1         synchronous reset, active-low
//   EN       in  1         sample strobe
//   SYNC     in  1         with EN, marks phase 0 of an I symbol
//   I_in     in  SAMPLE_W  in-phase sample, signed
//   Q_in     in  SAMPLE_W  quadrature sample, signed
//   BitOut   out 1         recovered bit
//   BitValid out 1         one-cycle strobe for BitOut/BitRail/WeakBit
//   BitRail  out 1         0 = I rail, 1 = Q rail
//   WeakBit  out 1         decision magnitude below MAG_THRESH
//   Locked   out 1         set by first bit after SYNC, cleared by SYNC or reset
module oqpsk_bit_recovery
  import oqpsk_pkg::*;
#(
  parameter int SAMPLE_W   = DEF_SAMPLE_W,
  parameter int SPB        = DEF_SPB,
  parameter int MAG_THRESH = DEF_MAG_THRESH
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                EN,
  input  logic                SYNC,
  input  logic [SAMPLE_W-1:0] I_in,
  input  logic [SAMPLE_W-1:0] Q_in,
  output logic                BitOut,
  output logic                BitValid,
  output logic                BitRail,
  output logic                WeakBit,
  output logic                Locked
);

  localparam int PW = $clog2(2*SPB);
  localparam int AW = SAMPLE_W + PW;
  localparam logic [PW-1:0] I_DUMP_PH = PW'(2*SPB-1);
  localparam logic [PW-1:0] Q_DUMP_PH = PW'(SPB-1);
  localparam logic [AW:0]   THRESH    = (AW+1)'(MAG_THRESH);

  state_t        state, next_state;
  logic [PW-1:0] phase;
  logic [PW-1:0] cur_phase;
  logic          sync_hit;
  logic          active;
  logic          i_dump, q_dump;
  logic          emit_i, emit_q, set_lock;
  logic [AW-1:0] i_sum, q_sum, dec_sum, mag;

  always_comb begin
    sync_hit  = EN && SYNC;
    // In IDLE only a SYNC sample is accepted; elsewhere every enabled sample counts.
    active    = EN && ((state != ST_IDLE) || SYNC);
    // The SYNC sample is phase 0 regardless of where the counter was.
    cur_phase = SYNC ? '0 : phase;
    i_dump    = active && (cur_phase == I_DUMP_PH);
    q_dump    = active && (cur_phase == Q_DUMP_PH);
  end

  oqpsk_integrate_dump #(.SAMPLE_W(SAMPLE_W), .AW(AW)) u_int_i (
    .clk    (CLK),
    .rstn   (RST),
    .clear  ((state == ST_IDLE) && !sync_hit),
    .add    (active),
    .start  (sync_hit),
    .dump   (i_dump),
    .sample (I_in),
    .sum    (i_sum)
  );

  // The Q accumulator also runs during the first half symbol; its dump at
  // phase SPB-1 just restarts it so the real Q window begins at phase SPB.
  oqpsk_integrate_dump #(.SAMPLE_W(SAMPLE_W), .AW(AW)) u_int_q (
    .clk    (CLK),
    .rstn   (RST),
    .clear  ((state == ST_IDLE) && !sync_hit),
    .add    (active),
    .start  (sync_hit),
    .dump   (q_dump),
    .sample (Q_in),
    .sum    (q_sum)
  );

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state <= ST_IDLE;
      phase <= '0;
    end else begin
      state <= next_state;
      if (active) begin
        phase <= cur_phase + 1'b1;
      end
    end
  end

  always_comb begin
    next_state = state;
    emit_i     = 1'b0;
    emit_q     = 1'b0;
    set_lock   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (sync_hit) next_state = ST_PRIME;
      end
      ST_PRIME: begin
        if (sync_hit) begin
          next_state = ST_PRIME;
        end else if (i_dump) begin
          emit_i     = 1'b1;
          set_lock   = 1'b1;
          next_state = ST_TRACK;
        end
      end
      ST_TRACK: begin
        if (sync_hit) begin
          next_state = ST_PRIME;
        end else begin
          emit_i = i_dump;
          emit_q = q_dump;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    dec_sum = emit_q ? q_sum : i_sum;
    // Negating the most negative value wraps to its correct unsigned magnitude.
    mag     = dec_sum[AW-1] ? -dec_sum : dec_sum;
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      BitOut   <= 1'b0;
      BitValid <= 1'b0;
      BitRail  <= 1'b0;
      WeakBit  <= 1'b0;
      Locked   <= 1'b0;
    end else begin
      BitValid <= emit_i || emit_q;
      if (emit_i || emit_q) begin
        BitOut  <= (!dec_sum[AW-1] && (dec_sum != '0)) ? POS_BIT : ~POS_BIT;
        BitRail <= emit_q;
        WeakBit <= ({1'b0, mag} < THRESH) || (dec_sum == '0);
      end
      if (sync_hit) begin
        Locked <= 1'b0;
      end else if (set_lock) begin
        Locked <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_oqpsk_bit_recovery.sv
// tb/tb_oqpsk_bit_recovery.sv - self-checking bench for oqpsk_bit_recovery
module tb_oqpsk_bit_recovery;
  import oqpsk_pkg::*;

  localparam int SYM  = 2*DEF_SPB;
  localparam int HALF = DEF_SPB;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        EN = 1'b0;
  logic        SYNC = 1'b0;
  logic [11:0] I_in = '0;
  logic [11:0] Q_in = '0;
  logic        BitOut, BitValid, BitRail, WeakBit, Locked;

  int   total = 0;
  int   bad = 0;
  int   si[0:255];
  int   sq[0:255];
  logic hb = 1'b0, hr = 1'b0, hw = 1'b0;
  logic got[$];
  logic ref_q[$];
  logic lb[8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

  oqpsk_bit_recovery dut (
    .CLK      (CLK),
    .RST      (RST),
    .EN       (EN),
    .SYNC     (SYNC),
    .I_in     (I_in),
    .Q_in     (Q_in),
    .BitOut   (BitOut),
    .BitValid (BitValid),
    .BitRail  (BitRail),
    .WeakBit  (WeakBit),
    .Locked   (Locked)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: a bit is due after the last sample of each full window.
  // I windows cover samples [n*SYM, n*SYM+SYM-1]; Q windows are offset by
  // HALF and the first Q window starts at sample HALF.
  function automatic void model(input int k, output logic v, output logic b,
                                output logic r, output logic w);
    int s = 0;
    v = 1'b0;
    r = 1'b0;
    if (k % SYM == SYM-1) begin
      v = 1'b1;
      for (int j = k-SYM+1; j <= k; j++) s += si[j];
    end else if ((k % SYM == HALF-1) && (k >= SYM+HALF-1)) begin
      v = 1'b1;
      r = 1'b1;
      for (int j = k-SYM+1; j <= k; j++) s += sq[j];
    end
    b = (s > 0);
    w = ((s < 0) ? -s : s) < DEF_MAG_THRESH;
  endfunction

  task automatic cycle_check(input string tag, input logic ev, input logic el);
    chk({tag, ".valid"}, int'(BitValid), int'(ev));
    chk({tag, ".bit"}, int'(BitOut), int'(hb));
    chk({tag, ".rail"}, int'(BitRail), int'(hr));
    chk({tag, ".weak"}, int'(WeakBit), int'(hw));
    chk({tag, ".locked"}, int'(Locked), int'(el));
  endtask

  // Drives si/sq[0..n-1] with SYNC on sample 0; gap<0 picks 0..2 idle cycles at random.
  task automatic run_stream(input string tag, input int n, input int gap);
    logic v, b, r, w;
    int   g;
    for (int k = 0; k < n; k++) begin
      EN   = 1'b1;
      SYNC = (k == 0);
      I_in = 12'(si[k]);
      Q_in = 12'(sq[k]);
      @(posedge CLK);
      #1;
      EN   = 1'b0;
      SYNC = 1'b0;
      model(k, v, b, r, w);
      if (v) begin
        hb = b;
        hr = r;
        hw = w;
      end
      if (BitValid) got.push_back(BitOut);
      cycle_check(tag, v, k >= SYM-1);
      g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      for (int i = 0; i < g; i++) begin
        I_in = 12'($urandom);
        Q_in = 12'($urandom);
        @(posedge CLK);
        #1;
        cycle_check({tag, ".gap"}, 1'b0, k >= SYM-1);
      end
    end
  endtask

  initial begin
    // Reset held with EN and random samples.
    RST = 1'b0;
    EN  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      I_in = 12'($urandom);
      Q_in = 12'($urandom);
      @(posedge CLK);
      #1;
      cycle_check("reset", 1'b0, 1'b0);
    end
    // Released without SYNC: nothing may come out.
    RST = 1'b1;
    for (int i = 0; i < 40; i++) begin
      I_in = 12'($urandom);
      Q_in = 12'($urandom);
      @(posedge CLK);
      #1;
      cycle_check("nosync", 1'b0, 1'b0);
    end
    EN = 1'b0;

    // Modulator loopback: rectangular OQPSK, Q delayed by half a symbol.
    for (int k = 0; k < 144; k++) begin
      si[k] = (k < 4*SYM) ? 500 * bit_level(lb[2*(k/SYM)]) : 0;
      sq[k] = (k >= HALF) ? 500 * bit_level(lb[2*((k-HALF)/SYM)+1]) : 0;
    end
    got.delete();
    run_stream("loop", 144, 0);
    chk("loop.count", got.size(), 8);
    for (int i = 0; i < 8 && i < got.size(); i++) chk("loop.seq", int'(got[i]), int'(lb[i]));

    // Constant I=+100, Q=-100, then the same stream with 3 of 4 cycles stalled.
    for (int k = 0; k < 96; k++) begin
      si[k] = 100;
      sq[k] = -100;
    end
    got.delete();
    run_stream("const", 96, 0);
    ref_q = got;
    got.delete();
    run_stream("stall", 96, 3);
    chk("stall.count", got.size(), ref_q.size());
    for (int i = 0; i < got.size() && i < ref_q.size(); i++)
      chk("stall.seq", int'(got[i]), int'(ref_q[i]));

    // Weak-decision boundaries over one I symbol.
    for (int k = 0; k < SYM; k++) begin si[k] = 2; sq[k] = 0; end
    run_stream("weak64", SYM, 0);
    chk("weak64.weak", int'(WeakBit), 0);
    for (int k = 0; k < SYM; k++) si[k] = 1;
    run_stream("weak32", SYM, 0);
    chk("weak32.weak", int'(WeakBit), 1);
    for (int k = 0; k < SYM; k++) si[k] = (k % 2 == 0) ? 5 : -5;
    run_stream("zero", SYM, 0);
    chk("zero.bit", int'(BitOut), 0);
    chk("zero.weak", int'(WeakBit), 1);

    // Random mix of large and near-threshold samples with random stalls.
    for (int k = 0; k < 200; k++) begin
      si[k] = (k % 64 < 32) ? int'($urandom_range(0, 4095)) - 2048 : int'($urandom_range(0, 8)) - 4;
      sq[k] = (k % 80 < 40) ? int'($urandom_range(0, 4095)) - 2048 : int'($urandom_range(0, 8)) - 4;
    end
    run_stream("rand", 200, -1);

    // Re-sync at phase 7 of TRACK: stop after 39 samples, restart with SYNC.
    for (int k = 0; k < 100; k++) begin
      si[k] = int'($urandom_range(0, 4095)) - 2048;
      sq[k] = int'($urandom_range(0, 4095)) - 2048;
    end
    run_stream("pre_resync", SYM+7, 0);
    chk("pre_resync.locked", int'(Locked), 1);
    for (int k = 0; k < 100; k++) si[k] = int'($urandom_range(0, 400)) - 200;
    run_stream("resync", 100, 0);

    // Reset mid-symbol discards partial sums.
    run_stream("pre_reset", 20, 0);
    RST = 1'b0;
    hb = 1'b0; hr = 1'b0; hw = 1'b0;
    @(posedge CLK);
    #1;
    cycle_check("midreset", 1'b0, 1'b0);
    RST = 1'b1;
    run_stream("post_reset", 64, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
